// File: rtl/hazard_tracker_pkg.sv
// Shared constants for the D-stage hazard tracker: forward-select encodings
// and the Tuse/Tnew field width.
package hazard_tracker_pkg;

    localparam int TNEW_W = 2;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_W    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;
    localparam logic [1:0] FWD_E    = 2'b11;

    localparam logic [TNEW_W-1:0] TUSE_NONE = 2'd3;

endpackage

// File: rtl/hazard_operand_check.sv
// Hazard and D-stage forward-select evaluation for one source operand against
// the E/M/W destination records.
module hazard_operand_check
    import hazard_tracker_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int T_W   = TNEW_W
) (
    input  logic [REG_W-1:0] operand_i,
    input  logic [T_W-1:0]   tuse_i,
    input  logic [REG_W-1:0] e_a3_i,
    input  logic [T_W-1:0]   e_tnew_i,
    input  logic [REG_W-1:0] m_a3_i,
    input  logic [T_W-1:0]   m_tnew_i,
    input  logic [REG_W-1:0] w_a3_i,
    input  logic [T_W-1:0]   w_tnew_i,
    output logic             hazard_o,
    output logic [1:0]       fwd_o
);

    logic op_nz;
    logic e_hit;
    logic m_hit;
    logic w_hit;

    // $0 is hard-wired, so an operand of zero never matches any record.
    assign op_nz = (operand_i != '0);
    assign e_hit = op_nz && (e_a3_i == operand_i);
    assign m_hit = op_nz && (m_a3_i == operand_i);
    assign w_hit = op_nz && (w_a3_i == operand_i);

    assign hazard_o = (e_hit && (tuse_i < e_tnew_i)) ||
                      (m_hit && (tuse_i < m_tnew_i));

    // The youngest matching stage owns the operand; if its value is not
    // ready yet, older stages hold stale data and must not be selected.
    always_comb begin
        fwd_o = FWD_NONE;
        if (e_hit) begin
            fwd_o = (e_tnew_i == '0) ? FWD_E : FWD_NONE;
        end else if (m_hit) begin
            fwd_o = (m_tnew_i == '0) ? FWD_M : FWD_NONE;
        end else if (w_hit) begin
            fwd_o = (w_tnew_i == '0) ? FWD_W : FWD_NONE;
        end
    end

endmodule

// File: rtl/hazard_tracker.sv
// Pipeline hazard tracker: shadows E/M/W destination/Tnew records and derives
// the D-stage stall plus every forwarding-mux select for D, E and M.
module hazard_tracker
    import hazard_tracker_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int T_W   = TNEW_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] D_rs,
    input  logic [REG_W-1:0] D_rt,
    input  logic [T_W-1:0]   D_rs_Tuse,
    input  logic [T_W-1:0]   D_rt_Tuse,
    input  logic [REG_W-1:0] D_A3,
    input  logic             D_regwe,
    input  logic [T_W-1:0]   D_Tnew,
    output logic             stall,
    output logic [1:0]       D_rs_fwd,
    output logic [1:0]       D_rt_fwd,
    output logic [1:0]       E_rs_fwd,
    output logic [1:0]       E_rt_fwd,
    output logic [1:0]       M_rt_fwd
);

    logic [REG_W-1:0] e_a3_q, e_a3_d, e_rs_q, e_rs_d, e_rt_q, e_rt_d;
    logic [T_W-1:0]   e_tnew_q, e_tnew_d;
    logic [REG_W-1:0] m_a3_q, m_a3_d, m_rt_q, m_rt_d;
    logic [T_W-1:0]   m_tnew_q, m_tnew_d;
    logic [REG_W-1:0] w_a3_q, w_a3_d;
    logic [T_W-1:0]   w_tnew_q, w_tnew_d;

    logic rs_hz;
    logic rt_hz;

    function automatic logic [T_W-1:0] tnew_dec(input logic [T_W-1:0] t);
        return (t == '0) ? '0 : t - T_W'(1);
    endfunction

    // Select from the M/W records for an operand already past D.
    function automatic logic [1:0] older_sel(
        input logic [REG_W-1:0] op,
        input logic [REG_W-1:0] m_a3,
        input logic [T_W-1:0]   m_tnew,
        input logic [REG_W-1:0] w_a3,
        input logic [T_W-1:0]   w_tnew
    );
        logic [1:0] sel;
        sel = FWD_NONE;
        if (op != '0 && op == m_a3) begin
            sel = (m_tnew == '0) ? FWD_M : FWD_NONE;
        end else if (op != '0 && op == w_a3) begin
            sel = (w_tnew == '0) ? FWD_W : FWD_NONE;
        end
        return sel;
    endfunction

    hazard_operand_check #(.REG_W(REG_W), .T_W(T_W)) u_rs_check (
        .operand_i (D_rs),
        .tuse_i    (D_rs_Tuse),
        .e_a3_i    (e_a3_q),
        .e_tnew_i  (e_tnew_q),
        .m_a3_i    (m_a3_q),
        .m_tnew_i  (m_tnew_q),
        .w_a3_i    (w_a3_q),
        .w_tnew_i  (w_tnew_q),
        .hazard_o  (rs_hz),
        .fwd_o     (D_rs_fwd)
    );

    hazard_operand_check #(.REG_W(REG_W), .T_W(T_W)) u_rt_check (
        .operand_i (D_rt),
        .tuse_i    (D_rt_Tuse),
        .e_a3_i    (e_a3_q),
        .e_tnew_i  (e_tnew_q),
        .m_a3_i    (m_a3_q),
        .m_tnew_i  (m_tnew_q),
        .w_a3_i    (w_a3_q),
        .w_tnew_i  (w_tnew_q),
        .hazard_o  (rt_hz),
        .fwd_o     (D_rt_fwd)
    );

    assign stall    = rs_hz | rt_hz;
    assign E_rs_fwd = older_sel(e_rs_q, m_a3_q, m_tnew_q, w_a3_q, w_tnew_q);
    assign E_rt_fwd = older_sel(e_rt_q, m_a3_q, m_tnew_q, w_a3_q, w_tnew_q);

    always_comb begin
        M_rt_fwd = FWD_NONE;
        if (m_rt_q != '0 && m_rt_q == w_a3_q && w_tnew_q == '0) begin
            M_rt_fwd = FWD_W;
        end
    end

    // A stalled D instruction leaves a zero bubble in E; M and W always advance.
    always_comb begin
        e_a3_d   = '0;
        e_tnew_d = '0;
        e_rs_d   = '0;
        e_rt_d   = '0;
        if (!stall) begin
            e_a3_d   = D_regwe ? D_A3 : '0;
            e_tnew_d = D_Tnew;
            e_rs_d   = D_rs;
            e_rt_d   = D_rt;
        end
        m_a3_d   = e_a3_q;
        m_tnew_d = tnew_dec(e_tnew_q);
        m_rt_d   = e_rt_q;
        w_a3_d   = m_a3_q;
        w_tnew_d = tnew_dec(m_tnew_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_a3_q   <= '0;
            e_tnew_q <= '0;
            e_rs_q   <= '0;
            e_rt_q   <= '0;
            m_a3_q   <= '0;
            m_tnew_q <= '0;
            m_rt_q   <= '0;
            w_a3_q   <= '0;
            w_tnew_q <= '0;
        end else begin
            e_a3_q   <= e_a3_d;
            e_tnew_q <= e_tnew_d;
            e_rs_q   <= e_rs_d;
            e_rt_q   <= e_rt_d;
            m_a3_q   <= m_a3_d;
            m_tnew_q <= m_tnew_d;
            m_rt_q   <= m_rt_d;
            w_a3_q   <= w_a3_d;
            w_tnew_q <= w_tnew_d;
        end
    end

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed bench for hazard_tracker: instruction sequences with hand-derived
// stall and forward-select values checked after each pipeline step.
module tb_hazard_tracker;
    import hazard_tracker_pkg::*;

    logic       clk;
    logic       reset;
    logic [4:0] D_rs, D_rt, D_A3;
    logic [1:0] D_rs_Tuse, D_rt_Tuse, D_Tnew;
    logic       D_regwe;
    logic       stall;
    logic [1:0] D_rs_fwd, D_rt_fwd, E_rs_fwd, E_rt_fwd, M_rt_fwd;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    hazard_tracker dut (
        .clk       (clk),
        .reset     (reset),
        .D_rs      (D_rs),
        .D_rt      (D_rt),
        .D_rs_Tuse (D_rs_Tuse),
        .D_rt_Tuse (D_rt_Tuse),
        .D_A3      (D_A3),
        .D_regwe   (D_regwe),
        .D_Tnew    (D_Tnew),
        .stall     (stall),
        .D_rs_fwd  (D_rs_fwd),
        .D_rt_fwd  (D_rt_fwd),
        .E_rs_fwd  (E_rs_fwd),
        .E_rt_fwd  (E_rt_fwd),
        .M_rt_fwd  (M_rt_fwd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic s, input logic [1:0] drs,
                              input logic [1:0] drt, input logic [1:0] ers,
                              input logic [1:0] ert, input logic [1:0] mrt);
        check({tag, ".stall"},    {1'b0, stall}, {1'b0, s});
        check({tag, ".D_rs_fwd"}, D_rs_fwd, drs);
        check({tag, ".D_rt_fwd"}, D_rt_fwd, drt);
        check({tag, ".E_rs_fwd"}, E_rs_fwd, ers);
        check({tag, ".E_rt_fwd"}, E_rt_fwd, ert);
        check({tag, ".M_rt_fwd"}, M_rt_fwd, mrt);
    endtask

    task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] rs_tuse,
                         input logic [1:0] rt_tuse, input logic [4:0] a3, input logic regwe,
                         input logic [1:0] tnew);
        D_rs      = rs;
        D_rt      = rt;
        D_rs_Tuse = rs_tuse;
        D_rt_Tuse = rt_tuse;
        D_A3      = a3;
        D_regwe   = regwe;
        D_Tnew    = tnew;
        #1;
    endtask

    task automatic set_nop();
        set_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, 1'b0, 2'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        set_nop();
        #1;
        check_outs("reset", 1'b0, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE);
        #10 reset = 1'b1;

        // lw $8,0($4) then addu $10,$8,$9: one bubble, then W forward into E
        set_d(5'd4, 5'd8, 2'd1, TUSE_NONE, 5'd8, 1'b1, 2'd2);
        check_outs("lw_in_d", 1'b0, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE);
        tick();
        set_d(5'd8, 5'd9, 2'd1, 2'd1, 5'd10, 1'b1, 2'd1);
        check_outs("lw_use_e", 1'b1, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE);
        tick();
        check_outs("lw_use_m", 1'b0, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE);
        tick();
        set_nop();
        check_outs("lw_use_fwd_w", 1'b0, FWD_NONE, FWD_NONE, FWD_W, FWD_NONE, FWD_NONE);

        // ori $9 then beq $9,$0
        set_d(5'd0, 5'd9, 2'd1, TUSE_NONE, 5'd9, 1'b1, 2'd1);
        tick();
        set_d(5'd9, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);
        check_outs("beq_stall", 1'b1, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE);
        tick();
        check_outs("beq_fwd_m", 1'b0, FWD_M, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE);
        tick();
        set_nop();
        check_outs("beq_in_e", 1'b0, FWD_NONE, FWD_NONE, FWD_W, FWD_NONE, FWD_NONE);

        // jal then jr $31
        set_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd31, 1'b1, 2'd0);
        tick();
        set_d(5'd31, 5'd0, 2'd0, TUSE_NONE, 5'd0, 1'b0, 2'd0);
        check_outs("jr_fwd_e", 1'b0, FWD_E, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE);
        tick();
        set_nop();
        check_outs("jr_in_e", 1'b0, FWD_NONE, FWD_NONE, FWD_M, FWD_NONE, FWD_NONE);

        // addu $0,$1,$2 then addu $3,$0,$0
        set_d(5'd1, 5'd2, 2'd1, 2'd1, 5'd0, 1'b1, 2'd1);
        tick();
        set_d(5'd0, 5'd0, 2'd1, 2'd1, 5'd3, 1'b1, 2'd1);
        check_outs("zero_reg_d", 1'b0, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE);
        tick();
        set_nop();
        check_outs("zero_reg_e", 1'b0, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE);

        // addu $5,$1,$2 then sw $5,0($29)
        set_d(5'd1, 5'd2, 2'd1, 2'd1, 5'd5, 1'b1, 2'd1);
        tick();
        set_d(5'd29, 5'd5, 2'd1, 2'd2, 5'd0, 1'b0, 2'd0);
        check_outs("sw_alu_d", 1'b0, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE);
        tick();
        set_nop();
        check_outs("sw_alu_e", 1'b0, FWD_NONE, FWD_NONE, FWD_NONE, FWD_M, FWD_NONE);
        tick();
        check_outs("sw_alu_m", 1'b0, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE, FWD_W);

        // lw $6,0($1) then sw $6,0($7)
        set_d(5'd1, 5'd6, 2'd1, TUSE_NONE, 5'd6, 1'b1, 2'd2);
        tick();
        set_d(5'd7, 5'd6, 2'd1, 2'd2, 5'd0, 1'b0, 2'd0);
        check_outs("sw_lw_d", 1'b0, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE);
        tick();
        set_nop();
        check_outs("sw_lw_e", 1'b0, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE);
        tick();
        check_outs("sw_lw_m", 1'b0, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE, FWD_W);

        // addu $6; lw $6; beq $6,$0: younger pending writer blocks older forwards
        set_d(5'd1, 5'd2, 2'd1, 2'd1, 5'd6, 1'b1, 2'd1);
        tick();
        set_d(5'd1, 5'd6, 2'd1, TUSE_NONE, 5'd6, 1'b1, 2'd2);
        tick();
        set_d(5'd6, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);
        check_outs("block_e_over_m", 1'b1, FWD_NONE, FWD_NONE, FWD_NONE, FWD_M, FWD_NONE);
        tick();
        check_outs("block_m_over_w", 1'b1, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE, FWD_W);
        tick();
        check_outs("block_release", 1'b0, FWD_W, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE);

        // reset asserted while stalled
        tick();
        set_d(5'd4, 5'd8, 2'd1, TUSE_NONE, 5'd8, 1'b1, 2'd2);
        tick();
        set_d(5'd8, 5'd9, 2'd1, 2'd1, 5'd10, 1'b1, 2'd1);
        check_outs("pre_reset_stall", 1'b1, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE);
        reset = 1'b0;
        #1;
        check_outs("reset_mid_stall", 1'b0, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE);
        tick();
        check_outs("reset_held", 1'b0, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE);
        #2 reset = 1'b1;
        tick();
        check_outs("restart_capture", 1'b0, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE);
        set_d(5'd10, 5'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0);
        check_outs("restart_hazard", 1'b1, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE, FWD_NONE);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
